// File: rtl/rr_arbiter_decode10.sv
// rr_arbiter_decode10
//   Round-robin arbiter that shares one 10-way resource among 10 requesters.
//   The winner is presented both as a binary index and as an active-low
//   one-hot select, matching the output form of a 4-to-10 active-low decoder.
//   A grant is force-released after HOLD_MAX consecutive cycles, and every
//   release passes through IDLE, so two grants are always separated by at
//   least one dead cycle.
//
// Ports
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous active-high reset
//   en        in   1   arbitration enable (blocks new grants only)
//   req       in   N   active-high request vector, bit i = requester i
//   gnt_n     out  N   active-low one-hot grant, all ones when idle
//   gnt_idx   out  IW  index of current grant / last winner
//   gnt_valid out  1   a grant is active
//   timeout   out  1   one-cycle pulse after a forced release
//
// Handshake: a requester holds req[i] high for as long as it wants the
// resource; the grant is live while gnt_valid=1 and gnt_idx=i. Dropping
// req[i] releases the grant at the next rising edge.

module rr_arbiter_decode10 #(
    parameter int N        = 10,
    parameter int IW       = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt_n,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid,
    output logic          timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [N-1:0]  ONE_HOT0     = N'(1);
    localparam logic [N-1:0]  ALL_OFF      = '1;
    localparam logic [IW-1:0] LAST_IDX     = IW'(N - 1);
    localparam logic [7:0]    HOLD_CNT_MAX = 8'(HOLD_MAX);

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_n_q, gnt_n_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;

    // Round-robin search. gnt_idx_q always equals the last winner, so it
    // doubles as the priority pointer: the search starts one past it and
    // wraps 9 -> 0, which makes the previous winner the lowest priority.
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = gnt_idx_q;
        for (int k = 0; k < N; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + IW'(1);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_n_d     = gnt_n_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && win_found) begin
                    state_d     = GRANT;
                    gnt_idx_d   = win_idx;
                    gnt_n_d     = ~(ONE_HOT0 << win_idx);
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd1;
                end
            end
            GRANT: begin
                // en is deliberately not consulted: an active grant runs on.
                if (!req[gnt_idx_q] || (hold_cnt_q == HOLD_CNT_MAX)) begin
                    state_d     = IDLE;
                    gnt_n_d     = ALL_OFF;
                    gnt_valid_d = 1'b0;
                    timeout_d   = req[gnt_idx_q];
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_n_q     <= ALL_OFF;
            gnt_idx_q   <= LAST_IDX;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            gnt_n_q     <= gnt_n_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt_n     = gnt_n_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

    // Output select must agree with the reported index.
    a_onehot_matches_idx : assert property (@(posedge clk) disable iff (rst)
        gnt_n == (gnt_valid ? ~(ONE_HOT0 << gnt_idx) : ALL_OFF));

endmodule

// File: tb/tb_rr_arbiter_decode10.sv
module tb_rr_arbiter_decode10;

  logic       clk;
  logic       rst;
  logic       en;
  logic [9:0] req;

  logic [9:0] gnt_n;
  logic [3:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  logic [9:0] gnt_n1;
  logic [3:0] gnt_idx1;
  logic       gnt_valid1;
  logic       timeout1;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q[$];

  rr_arbiter_decode10 #(.HOLD_MAX(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt_n     (gnt_n),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  // Single-cycle-grant variant, only checked during the sole-requester phase.
  rr_arbiter_decode10 #(.HOLD_MAX(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt_n     (gnt_n1),
    .gnt_idx   (gnt_idx1),
    .gnt_valid (gnt_valid1),
    .timeout   (timeout1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] sel_n(input int w);
    logic [9:0] one;
    one = 10'b1;
    return ~(one << w);
  endfunction

  task automatic check_grant(input string tag, input int w);
    check({tag, "_valid"}, 32'(gnt_valid), 32'd1);
    check({tag, "_idx"}, 32'(gnt_idx), 32'(w));
    check({tag, "_gnt_n"}, 32'(gnt_n), 32'(sel_n(w)));
  endtask

  task automatic check_idle(input string tag, input int last, input logic to);
    check({tag, "_valid"}, 32'(gnt_valid), 32'd0);
    check({tag, "_idx"}, 32'(gnt_idx), 32'(last));
    check({tag, "_gnt_n"}, 32'(gnt_n), 32'h3FF);
    check({tag, "_timeout"}, 32'(timeout), 32'(to));
  endtask

  // invariant monitor on the main instance
  always @(negedge clk) begin
    check("invariant", 32'(gnt_n), gnt_valid ? 32'(sel_n(int'(gnt_idx))) : 32'h3FF);
  end

  initial begin
    int w;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    en  = 1'b0;
    req = 10'h000;
    step();
    step();
    check_idle("reset", 9, 1'b0);
    rst = 1'b0;

    // idle with no requests
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle("no_req", 9, 1'b0);
    end

    // sole requester 0 held 3 cycles then dropped
    en  = 1'b1;
    req = 10'h001;
    step();
    check_grant("solo_a", 0);
    check("h1_a_valid", 32'(gnt_valid1), 32'd1);
    check("h1_a_idx", 32'(gnt_idx1), 32'd0);
    step();
    check_grant("solo_b", 0);
    check("h1_b_valid", 32'(gnt_valid1), 32'd0);
    check("h1_b_timeout", 32'(timeout1), 32'd1);
    check("h1_b_gnt_n", 32'(gnt_n1), 32'h3FF);
    step();
    check_grant("solo_c", 0);
    check("h1_c_valid", 32'(gnt_valid1), 32'd1);
    check("h1_c_timeout", 32'(timeout1), 32'd0);
    check("h1_c_gnt_n", 32'(gnt_n1), 32'h3FE);
    req = 10'h000;
    step();
    check_idle("solo_drop", 0, 1'b0);
    check("h1_d_valid", 32'(gnt_valid1), 32'd0);
    check("h1_d_timeout", 32'(timeout1), 32'd0);

    // reset again so requester 0 leads the full rotation
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("reset2", 9, 1'b0);

    // all request continuously: 0..9,0 each for 16 cycles with forced release
    for (int g = 0; g <= 10; g++) exp_q.push_back(32'(g % 10));
    req = 10'h3FF;
    while (exp_q.size() > 0) begin
      w = int'(exp_q.pop_front());
      for (int c = 0; c < 16; c++) begin
        step();
        check("rr_valid", 32'(gnt_valid), 32'd1);
        check("rr_idx", 32'(gnt_idx), 32'(w));
        check("rr_timeout", 32'(timeout), 32'd0);
      end
      check("rr_gnt_n", 32'(gnt_n), 32'(sel_n(w)));
      step();
      check_idle("rr_forced", w, 1'b1);
    end
    req = 10'h000;
    step();
    check_idle("rr_after", 0, 1'b0);

    // requesters 2 and 9: order 2, 9, 2 with dead cycles
    req = 10'h204;
    step();
    check_grant("p2_first", 2);
    step();
    check_grant("p2_hold", 2);
    req = 10'h200;
    step();
    check_idle("p2_rel", 2, 1'b0);
    req = 10'h204;
    step();
    check_grant("p9", 9);
    req = 10'h004;
    step();
    check_idle("p9_rel", 9, 1'b0);
    step();
    check_grant("p2_again", 2);
    req = 10'h000;
    step();
    check_idle("p2_end", 2, 1'b0);

    // enable gating
    en  = 1'b0;
    req = 10'h010;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("en_off", 2, 1'b0);
    end
    en = 1'b1;
    step();
    check_grant("en_on", 4);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_grant("en_drop", 4);
    end
    req = 10'h000;
    step();
    check_idle("en_rel", 4, 1'b0);

    // asynchronous reset in the middle of a grant
    en  = 1'b1;
    req = 10'h3FF;
    step();
    check_grant("pre_arst", 5);
    #3;
    rst = 1'b1;
    #1;
    check_idle("arst", 9, 1'b0);
    step();
    check_idle("arst_hold", 9, 1'b0);
    rst = 1'b0;
    step();
    check_grant("post_arst", 0);
    req = 10'h000;
    step();
    check_idle("final", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_decode10.md
Name: rr_arbiter_decode10

Overview:
- Round-robin arbiter sharing one 10-way resource among 10 requesters.
- Selects one winner and presents it two ways:
  - as a 4-bit binary index;
  - as a 10-bit active-low one-hot select, in the same form as the 4-to-10 active-low decoder output (winner bit 0, all others 1).
- Enforces a maximum hold time per grant and at least one dead cycle between grants.
- Sits between the requesters and the shared 10-line select bus.

Parameters:
- N, 10, number of requesters; fixed at 10, not user-overridable beyond 10.
- IW, 4, index width; must satisfy 2**IW >= N.
- HOLD_MAX, 16, maximum consecutive cycles one grant may be held; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  arbitration enable; 0 blocks new grants, an active grant continues.
- req  input  10  request vector, active-high, bit i = requester i.
- gnt_n  output  10  active-low one-hot grant; 10'h3FF when no grant.
- gnt_idx  output  4  binary index of current grant; holds last winner when gnt_valid=0.
- gnt_valid  output  1  1 while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released at HOLD_MAX.

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-grant):
  - state=IDLE, gnt_n=10'h3FF, gnt_idx=4'd9, gnt_valid=0, timeout=0, hold_cnt=0;
  - internal last-winner pointer=9, so requester 0 has top priority after reset.
- Release of rst is synchronous to clk; the first arbitration happens on the first rising edge with rst=0.
- States: IDLE, GRANT.
- IDLE, sampled at a rising edge:
  - If en=1 and req!=0: winner w = first set bit of req searching (last+1) mod 10, (last+2) mod 10, ... with wrap from 9 to 0.
  - At that same edge: state=GRANT, gnt_idx=w, gnt_n=~(10'b1<<w), gnt_valid=1, hold_cnt=1, last=w.
  - Latency: req visible before edge k gives the grant at outputs after edge k (one cycle).
  - If en=0 or req==0: stay IDLE, outputs unchanged.
- GRANT, at each rising edge:
  - If req[gnt_idx]=0: voluntary release. state=IDLE, gnt_n=10'h3FF, gnt_valid=0, timeout=0.
  - Else if hold_cnt==HOLD_MAX: forced release. Same outputs as voluntary release, but timeout=1 for exactly one cycle.
  - Else: hold_cnt=hold_cnt+1; grant outputs unchanged.
  - The en input is ignored while in GRANT.
- Dead cycle: a release edge always goes to IDLE, so there is at least one cycle with gnt_n=10'h3FF between any two grants. Consecutive grants never overlap or abut.
- Grant duration:
  - A held request is granted for exactly HOLD_MAX cycles.
  - HOLD_MAX=1 gives single-cycle grants.
- Fairness:
  - After a release, the releasing requester has lowest priority.
  - A force-released requester that still requests is served again only after every other pending requester.
  - A sole requester is regranted after one dead cycle.
- Requests changing at the arbitration edge: only values sampled at that edge count. Other req bits changing during GRANT have no effect.
- timeout is 0 in every cycle except the one following a forced release.
- Width rules:
  - hold_cnt is 8 bits unsigned and is compared for equality only.
  - Pointer arithmetic is mod 10; indices 10..15 are never produced.
- Invariant, checked by assertion: gnt_valid=1 implies exactly one 0 in gnt_n, at position gnt_idx; gnt_valid=0 implies gnt_n=10'h3FF.

Test Plan:
- Reset then req=10'h000 for 10 cycles -> gnt_n=10'h3FF, gnt_valid=0, gnt_idx=9 throughout.
- req=10'h001 held 3 cycles then dropped -> gnt_idx=0, gnt_n=10'h3FE, valid for 3 cycles; 3FF the cycle after the drop.
- req=10'h3FF held, HOLD_MAX=16 -> grants 0,1,...,9,0 in order:
  - each grant lasts 16 cycles;
  - one dead cycle between grants;
  - timeout pulses once per grant.
- req=10'h204 (bits 2 and 9) with requester 2 releasing after 2 cycles -> order 2, 9, 2; dead cycle between each.
- en=0 with req=10'h010 -> no grant. Raise en -> gnt_idx=4, gnt_n=10'h3EF one cycle later. Drop en mid-grant -> grant persists until req[4]=0.
- Assert rst asynchronously mid-grant (between edges) -> gnt_n=10'h3FF and gnt_valid=0 immediately. After release with req=10'h3FF -> first grant is index 0.
